// File: rtl/lms_fir_engine_if.sv
// Request/result bundle of the serial LMS FIR engine: operands and start go in,
// busy/done and the registered y, err, power and ovf come back.
interface lms_fir_engine_if #(
    parameter int TAPS   = 32,
    parameter int DATA_W = 14,
    parameter int COEF_W = 16
);
    localparam int PW = 2 * DATA_W + $clog2(TAPS);

    // start is sampled only while the engine is idle. ref_bus and coef_bus
    // must stay stable while busy is high.
    logic                     start;
    logic [TAPS*DATA_W-1:0]   ref_bus;
    logic [TAPS*COEF_W-1:0]   coef_bus;
    logic [DATA_W-1:0]        desired;
    logic                     busy;
    logic                     done;
    logic [DATA_W-1:0]        y;
    logic [DATA_W-1:0]        err;
    logic [PW-1:0]            power;
    logic                     ovf;

    modport master (
        output start, ref_bus, coef_bus, desired,
        input  busy, done, y, err, power, ovf
    );

    modport slave (
        input  start, ref_bus, coef_bus, desired,
        output busy, done, y, err, power, ovf
    );
endinterface

// File: rtl/lms_fir_engine.sv
// Serial LMS FIR datapath: one shared MAC walks the taps to form y, err and the
// reference power. A three-stage pipeline is drained by FLUSH before results are registered.
module lms_fir_engine #(
    parameter int TAPS   = 32,
    parameter int DATA_W = 14,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 10,
    parameter int SAT_EN = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    lms_fir_engine_if.slave    bus,
    output logic [1:0]         o_state
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SQ_W   = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam int PW     = SQ_W + IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_flush;
    logic signed [DATA_W-1:0]   r_desired;
    logic                       r_v1, r_v2;
    logic signed [DATA_W-1:0]   r_ref1;
    logic signed [COEF_W-1:0]   r_coef1;
    logic signed [PROD_W-1:0]   r_prod;
    logic [SQ_W-1:0]            r_sq;
    logic signed [ACC_W-1:0]    r_acc;
    logic [PW-1:0]              r_pacc;
    logic                       r_done;
    logic [DATA_W-1:0]          r_y, r_err;
    logic [PW-1:0]              r_power;
    logic                       r_ovf;

    logic signed [DATA_W-1:0]   w_ref;
    logic signed [COEF_W-1:0]   w_coef;
    logic signed [ACC_W-1:0]    w_ys;
    logic                       w_ovf_y, w_ovf_e;
    logic [DATA_W-1:0]          w_y, w_err;
    logic [DATA_W:0]            w_e;
    logic [DATA_W-1:0]          w_max, w_min;

    assign w_ref  = bus.ref_bus[int'(r_idx) * DATA_W +: DATA_W];
    assign w_coef = bus.coef_bus[int'(r_idx) * COEF_W +: COEF_W];
    assign w_max  = {1'b0, {(DATA_W-1){1'b1}}};
    assign w_min  = {1'b1, {(DATA_W-1){1'b0}}};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_idx == IDX_W'(TAPS - 1)) w_next = S_FLUSH;
            S_FLUSH: if (r_flush) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Result formatting: ys fits DATA_W only if every bit above the sign agrees with it.
    always_comb begin
        w_ys    = r_acc >>> SHIFT;
        w_ovf_y = !((&w_ys[ACC_W-1:DATA_W-1]) || !(|w_ys[ACC_W-1:DATA_W-1]));
        w_y     = w_ys[DATA_W-1:0];
        if (SAT_EN != 0 && w_ovf_y) w_y = w_ys[ACC_W-1] ? w_min : w_max;
        w_e     = {r_desired[DATA_W-1], r_desired} - {w_y[DATA_W-1], w_y};
        w_ovf_e = w_e[DATA_W] != w_e[DATA_W-1];
        w_err   = w_e[DATA_W-1:0];
        if (SAT_EN != 0 && w_ovf_e) w_err = w_e[DATA_W] ? w_min : w_max;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_flush   <= 1'b0;
            r_desired <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_ref1    <= '0;
            r_coef1   <= '0;
            r_prod    <= '0;
            r_sq      <= '0;
            r_acc     <= '0;
            r_pacc    <= '0;
            r_done    <= 1'b0;
            r_y       <= '0;
            r_err     <= '0;
            r_power   <= PW'(1);
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_v1    <= (r_state == S_RUN);
            r_ref1  <= w_ref;
            r_coef1 <= w_coef;
            r_v2    <= r_v1;
            r_prod  <= r_ref1 * r_coef1;
            r_sq    <= r_ref1 * r_ref1;
            if (r_v2) begin
                r_acc  <= r_acc + {{IDX_W{r_prod[PROD_W-1]}}, r_prod};
                r_pacc <= r_pacc + {{IDX_W{1'b0}}, r_sq};
            end
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_idx     <= '0;
                    r_flush   <= 1'b0;
                    r_desired <= bus.desired;
                    r_acc     <= '0;
                    r_pacc    <= '0;
                end
                S_RUN:   r_idx <= (r_idx == IDX_W'(TAPS - 1)) ? '0 : r_idx + 1'b1;
                S_FLUSH: r_flush <= 1'b1;
                S_DONE: begin
                    r_y     <= w_y;
                    r_err   <= w_err;
                    r_ovf   <= w_ovf_y | w_ovf_e;
                    r_power <= (r_pacc != '0) ? r_pacc : PW'(1);
                end
                default: ;
            endcase
        end
    end

    // busy covers the done cycle so a held start sees no gap between operations.
    assign bus.busy  = (r_state != S_IDLE) || r_done;
    assign bus.done  = r_done;
    assign bus.y     = r_y;
    assign bus.err   = r_err;
    assign bus.power = r_power;
    assign bus.ovf   = r_ovf;
    assign o_state   = r_state;
endmodule
